// File: rtl/uart_pkg.sv
// Shared constants and types for the parametrised UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Parity mode encoding used by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Bit-counter value at which a bit is sampled (middle of the bit)
  function automatic int sample_point(input int clk_div);
    return clk_div / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; head word always on pop_dat.
// Latency: a push is visible on pop_dat / empty the following cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so push-while-full is fine then
  assign do_push = push && (!full || do_pop);
  // Head word is forced to zero while empty so the output is stable
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the head
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (sync, false-start reject, parity/frame check) into a FWFT FIFO.
// Latency: word on rx_data / error pulse one cycle after the final stop-bit sample.
// Backpressure: rx_valid/rx_ready drain; good words arriving while full are dropped with overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 busy
);

  localparam int              HALF      = sample_point(CLK_DIV);
  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   CNT_SMP   = CW'(HALF);
  localparam logic [3:0]      DBIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      SBIT_LAST = 4'(STOP_BITS - 1);

  logic                 rxd_m, rxd_s, rxd_s_d;
  logic [1:0]           warm;
  logic                 start_edge;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt;
  logic                 sample;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 stop_bad_q;
  logic                 shift_en, par_en, bit_inc, bit_clr, frame_done;
  logic                 stop_low, par_x, par_ok, good;
  logic                 fifo_full, fifo_empty, pop;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_s_d <= 1'b1;
    end else begin
      rxd_m   <= uart_rxd;
      rxd_s   <= rxd_m;
      rxd_s_d <= rxd_s;
    end
  end

  // Hold off edge detection until the sync chain holds real line samples,
  // otherwise a line held low through reset would look like a start edge
  always_ff @(posedge sys_clk) begin
    if (sys_rst)           warm <= 2'd0;
    else if (warm != 2'd3) warm <= warm + 2'd1;
  end

  assign start_edge = (warm == 2'd3) && rxd_s_d && !rxd_s;
  assign sample     = (cnt == CNT_SMP);
  assign busy       = (state_q != ST_IDLE);

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Bit-period counter; the edge-detect cycle counts as 0
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                 cnt <= '0;
    else if (state_q == ST_IDLE) cnt <= start_edge ? CW'(1) : '0;
    else if (state_d == ST_IDLE) cnt <= '0;
    else if (cnt == CNT_MAX)     cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_d    = state_q;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    bit_inc    = 1'b0;
    bit_clr    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_START;
          bit_clr = 1'b1;
        end
      end
      ST_START: begin
        if (sample) begin
          // Line back high mid start bit: glitch, not a frame
          state_d = rxd_s ? ST_IDLE : ST_DATA;
          bit_clr = 1'b1;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == DBIT_LAST) begin
            bit_clr = 1'b1;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_en  = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          // Leave mid stop bit so a back-to-back start edge is not missed
          if (bit_cnt == SBIT_LAST) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift register, parity bit, stop-bit error accumulation and bit index
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) begin
        if (DATA_BITS > 1) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        else               shreg <= rxd_s;
      end
      if (par_en) par_q <= rxd_s;
      if (state_q == ST_IDLE)                         stop_bad_q <= 1'b0;
      else if (state_q == ST_STOP && sample && !rxd_s) stop_bad_q <= 1'b1;
    end
  end

  // Frame verdict, decided in the final stop-sample cycle
  always_comb begin
    stop_low = stop_bad_q || !rxd_s;
    par_x    = (^shreg) ^ par_q;
    if (PARITY == PAR_ODD)       par_ok = par_x;
    else if (PARITY == PAR_EVEN) par_ok = !par_x;
    else                         par_ok = 1'b1;
    good = frame_done && !stop_low && par_ok;
  end

  // Registered one-cycle status pulses; frame error masks parity error
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_err  <= frame_done && stop_low;
      parity_err <= frame_done && !stop_low && !par_ok;
      overflow   <= good && fifo_full && !pop;
    end
  end

  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .push     (good),
    .push_dat (shreg),
    .pop      (pop),
    .pop_dat  (rx_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 7N2) on separate lines.
// Expected words are queued when a frame is sent and checked against popped words.
// Timing reference: a bit driven in cycle c reaches rxd_s in c+2 (edge-detect cycle).
module tb_uart_rx_fifo;

  localparam int CD   = 25;
  localparam int HALF = CD / 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] rxd;
  logic [2:0] rdy;
  wire  [2:0] vld, pe, fe, ov, bsy;
  wire  [7:0] dat0, dat1;
  wire  [6:0] dat2;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_start;
  int pe_cnt [3];
  int fe_cnt [3];
  int ov_cnt [3];
  int multi;
  int vld0_hi;
  int rise0;
  logic vld0_prev;
  logic busy0_seen;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] exp2 [$];
  logic [7:0] obs0 [$];
  logic [7:0] obs1 [$];
  logic [7:0] obs2 [$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_rx_fifo #(.CLK_DIV(CD)) u_8n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[0]),
    .rx_data(dat0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overflow(ov[0]), .busy(bsy[0]));

  uart_rx_fifo #(.CLK_DIV(CD), .PARITY(2)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[1]),
    .rx_data(dat1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overflow(ov[1]), .busy(bsy[1]));

  uart_rx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[2]),
    .rx_data(dat2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overflow(ov[2]), .busy(bsy[2]));

  // Output monitor on the falling edge: pulse counters and popped words
  always @(negedge sys_clk) begin
    for (int i = 0; i < 3; i++) begin
      pe_cnt[i] += int'(pe[i]);
      fe_cnt[i] += int'(fe[i]);
      ov_cnt[i] += int'(ov[i]);
      if (int'(pe[i]) + int'(fe[i]) + int'(ov[i]) > 1) multi++;
    end
    if (vld[0]) vld0_hi++;
    if (vld[0] && !vld0_prev) rise0 = cyc;
    vld0_prev = vld[0];
    if (bsy[0]) busy0_seen = 1'b1;
    if (vld[0] && rdy[0]) obs0.push_back(dat0);
    if (vld[1] && rdy[1]) obs1.push_back(dat1);
    if (vld[2] && rdy[2]) obs2.push_back({1'b0, dat2});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Serialise one frame LSB first; par_flip corrupts the parity bit,
  // stop_v is the value of the last stop bit
  task automatic send_frame(input int inst, input logic [7:0] d, input int nd,
                            input int pmode, input logic par_flip,
                            input logic stop_v, input int nstop);
    logic [15:0] bits;
    logic [7:0]  mask;
    logic        p;
    int          n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
    if (pmode != 0) begin
      mask = (8'h01 << nd) - 8'h01;
      p = ^(d & mask);
      if (pmode == 1) p = ~p;
      bits[n] = p ^ par_flip; n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = (i == nstop - 1) ? stop_v : 1'b1; n++;
    end
    last_start = cyc;
    for (int i = 0; i < n; i++) begin
      rxd[inst] = bits[i];
      tick(CD);
    end
    rxd[inst] = 1'b1;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    tick(4);
    vectors++; if (vld !== 3'b000) begin miscompares++; $display("FAIL reset_valid: got %b required 000", vld); end
    vectors++; if ({dat0, dat1, dat2} !== 23'd0) begin miscompares++; $display("FAIL reset_data: got %h %h %h required 0", dat0, dat1, dat2); end
    vectors++; if ((pe | fe | ov) !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got pe %b fe %b ov %b required 0", pe, fe, ov); end
    vectors++; if (bsy !== 3'b000) begin miscompares++; $display("FAIL reset_busy: got %b required 000", bsy); end
    sys_rst = 1'b0;
    tick(6);
    vectors++; if ((bsy | vld) !== 3'b000) begin miscompares++; $display("FAIL post_reset_idle: got busy %b valid %b required 0", bsy, vld); end
  endtask

  task automatic test_basic;
    int c, p0, f0, o0;
    logic [7:0] got, want;
    p0 = pe_cnt[0]; f0 = fe_cnt[0]; o0 = ov_cnt[0];
    vld0_hi = 0; rise0 = -1; rdy[0] = 1'b1;
    exp0.push_back(8'hA5);
    send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1, 1);
    c = last_start;
    tick(CD);
    // last stop sample at c+2+HALF+9*CD, word visible one cycle later
    vectors++; if (rise0 !== c + 2 + HALF + 9 * CD + 1) begin miscompares++; $display("FAIL basic_latency: got cycle %0d required %0d", rise0, c + 2 + HALF + 9 * CD + 1); end
    vectors++; if (vld0_hi !== 1) begin miscompares++; $display("FAIL basic_valid_width: got %0d cycles required 1", vld0_hi); end
    vectors++; if (pe_cnt[0] - p0 + fe_cnt[0] - f0 + ov_cnt[0] - o0 !== 0) begin miscompares++; $display("FAIL basic_flags: got %0d pulses required 0", pe_cnt[0] - p0 + fe_cnt[0] - f0 + ov_cnt[0] - o0); end
    while (exp0.size() > 0) begin
      want = exp0.pop_front();
      vectors++;
      if (obs0.size() == 0) begin miscompares++; $display("FAIL basic_word: got none required %h", want); end
      else begin got = obs0.pop_front(); if (got !== want) begin miscompares++; $display("FAIL basic_word: got %h required %h", got, want); end end
    end
    vectors++; if (obs0.size() != 0) begin miscompares++; $display("FAIL basic_extra: got %0d extra words required 0", obs0.size()); obs0.delete(); end
  endtask

  task automatic test_parity;
    int p1, f1;
    logic [7:0] got, want;
    rdy[1] = 1'b1;
    p1 = pe_cnt[1]; f1 = fe_cnt[1];
    send_frame(1, 8'h03, 8, 2, 1'b1, 1'b1, 1);
    tick(CD);
    vectors++; if (pe_cnt[1] - p1 !== 1) begin miscompares++; $display("FAIL parity_err_pulse: got %0d pulses required 1", pe_cnt[1] - p1); end
    vectors++; if (obs1.size() != 0) begin miscompares++; $display("FAIL parity_drop: got %0d words required 0", obs1.size()); obs1.delete(); end
    exp1.push_back(8'h03);
    send_frame(1, 8'h03, 8, 2, 1'b0, 1'b1, 1);
    tick(CD);
    vectors++; if (pe_cnt[1] - p1 !== 1 || fe_cnt[1] - f1 !== 0) begin miscompares++; $display("FAIL parity_good_flags: got pe %0d fe %0d required 1 0", pe_cnt[1] - p1, fe_cnt[1] - f1); end
    while (exp1.size() > 0) begin
      want = exp1.pop_front();
      vectors++;
      if (obs1.size() == 0) begin miscompares++; $display("FAIL parity_word: got none required %h", want); end
      else begin got = obs1.pop_front(); if (got !== want) begin miscompares++; $display("FAIL parity_word: got %h required %h", got, want); end end
    end
    vectors++; if (obs1.size() != 0) begin miscompares++; $display("FAIL parity_extra: got %0d extra words required 0", obs1.size()); obs1.delete(); end
  endtask

  task automatic test_frame;
    int p0, f0;
    logic [7:0] got, want;
    rdy[0] = 1'b1;
    p0 = pe_cnt[0]; f0 = fe_cnt[0];
    send_frame(0, 8'h55, 8, 0, 1'b0, 1'b0, 1);
    tick(CD);
    vectors++; if (fe_cnt[0] - f0 !== 1) begin miscompares++; $display("FAIL frame_err_pulse: got %0d pulses required 1", fe_cnt[0] - f0); end
    vectors++; if (obs0.size() != 0) begin miscompares++; $display("FAIL frame_drop: got %0d words required 0", obs0.size()); obs0.delete(); end
    exp0.push_back(8'h12);
    send_frame(0, 8'h12, 8, 0, 1'b0, 1'b1, 1);
    tick(CD);
    vectors++; if (fe_cnt[0] - f0 !== 1 || pe_cnt[0] - p0 !== 0) begin miscompares++; $display("FAIL frame_next_flags: got fe %0d pe %0d required 1 0", fe_cnt[0] - f0, pe_cnt[0] - p0); end
    while (exp0.size() > 0) begin
      want = exp0.pop_front();
      vectors++;
      if (obs0.size() == 0) begin miscompares++; $display("FAIL frame_next_word: got none required %h", want); end
      else begin got = obs0.pop_front(); if (got !== want) begin miscompares++; $display("FAIL frame_next_word: got %h required %h", got, want); end end
    end
  endtask

  task automatic test_false_start;
    int c, f0, p0, o0;
    f0 = fe_cnt[0]; p0 = pe_cnt[0]; o0 = ov_cnt[0];
    busy0_seen = 1'b0;
    c = cyc;
    rxd[0] = 1'b0;
    tick(5);
    rxd[0] = 1'b1;
    // start sample at c+2+HALF sees the line high again; IDLE from c+3+HALF
    tick(c + 4 + HALF - cyc);
    vectors++; if (busy0_seen !== 1'b1) begin miscompares++; $display("FAIL false_start_busy_seen: got %b required 1", busy0_seen); end
    vectors++; if (bsy[0] !== 1'b0) begin miscompares++; $display("FAIL false_start_busy_drop: got %b required 0", bsy[0]); end
    tick(2 * CD);
    vectors++; if (fe_cnt[0] - f0 + pe_cnt[0] - p0 + ov_cnt[0] - o0 !== 0 || vld[0] !== 1'b0) begin miscompares++; $display("FAIL false_start_quiet: got %0d pulses valid %b required 0 0", fe_cnt[0] - f0 + pe_cnt[0] - p0 + ov_cnt[0] - o0, vld[0]); end
  endtask

  task automatic test_overflow;
    int o0;
    logic [7:0] got, want;
    o0 = ov_cnt[0];
    rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp0.push_back(8'(i));
      send_frame(0, 8'(i), 8, 0, 1'b0, 1'b1, 1);
    end
    tick(CD);
    vectors++; if (ov_cnt[0] - o0 !== 1) begin miscompares++; $display("FAIL overflow_pulse: got %0d pulses required 1", ov_cnt[0] - o0); end
    vectors++; if (vld[0] !== 1'b1 || dat0 !== 8'h01) begin miscompares++; $display("FAIL overflow_head: got valid %b data %h required 1 01", vld[0], dat0); end
    rdy[0] = 1'b1;
    tick(8);
    while (exp0.size() > 0) begin
      want = exp0.pop_front();
      vectors++;
      if (obs0.size() == 0) begin miscompares++; $display("FAIL overflow_drain: got none required %h", want); end
      else begin got = obs0.pop_front(); if (got !== want) begin miscompares++; $display("FAIL overflow_drain: got %h required %h", got, want); end end
    end
    vectors++; if (obs0.size() != 0 || vld[0] !== 1'b0) begin miscompares++; $display("FAIL overflow_empty: got %0d extra words valid %b required 0 0", obs0.size(), vld[0]); obs0.delete(); end
  endtask

  task automatic test_reset_mid;
    int f2, p2;
    logic [7:0] got, want;
    f2 = fe_cnt[2]; p2 = pe_cnt[2];
    rdy[2] = 1'b0;
    send_frame(2, 8'h15, 7, 0, 1'b0, 1'b1, 2);
    tick(CD);
    vectors++; if (vld[2] !== 1'b1) begin miscompares++; $display("FAIL reset_mid_parked: got valid %b required 1", vld[2]); end
    rxd[2] = 1'b0;
    tick(3 * CD);
    vectors++; if (bsy[2] !== 1'b1) begin miscompares++; $display("FAIL reset_mid_busy: got %b required 1", bsy[2]); end
    sys_rst = 1'b1;
    tick(3);
    vectors++; if (vld[2] !== 1'b0 || dat2 !== 7'h00 || bsy[2] !== 1'b0) begin miscompares++; $display("FAIL reset_mid_flush: got valid %b data %h busy %b required 0 00 0", vld[2], dat2, bsy[2]); end
    // line still low when reset releases: must not be taken as a start
    sys_rst = 1'b0;
    tick(2 * CD);
    rxd[2] = 1'b1;
    tick(CD);
    vectors++; if (bsy[2] !== 1'b0 || fe_cnt[2] - f2 + pe_cnt[2] - p2 !== 0 || vld[2] !== 1'b0) begin miscompares++; $display("FAIL reset_mid_quiet: got busy %b pulses %0d valid %b required 0 0 0", bsy[2], fe_cnt[2] - f2 + pe_cnt[2] - p2, vld[2]); end
    rdy[2] = 1'b1;
    exp2.push_back(8'h7F);
    send_frame(2, 8'h7F, 7, 0, 1'b0, 1'b1, 2);
    tick(CD);
    while (exp2.size() > 0) begin
      want = exp2.pop_front();
      vectors++;
      if (obs2.size() == 0) begin miscompares++; $display("FAIL reset_mid_word: got none required %h", want); end
      else begin got = obs2.pop_front(); if (got !== want) begin miscompares++; $display("FAIL reset_mid_word: got %h required %h", got, want); end end
    end
    vectors++; if (obs2.size() != 0) begin miscompares++; $display("FAIL reset_mid_extra: got %0d extra words required 0", obs2.size()); obs2.delete(); end
  endtask

  initial begin
    sys_rst = 1'b1;
    rxd = 3'b111;
    rdy = 3'b111;
    multi = 0;
    vld0_hi = 0;
    rise0 = -1;
    vld0_prev = 1'b0;
    busy0_seen = 1'b0;
    last_start = 0;
    for (int i = 0; i < 3; i++) begin
      pe_cnt[i] = 0; fe_cnt[i] = 0; ov_cnt[i] = 0;
    end
    tick(1);
    test_reset;
    test_basic;
    test_parity;
    test_frame;
    test_false_start;
    test_overflow;
    test_reset_mid;
    vectors++; if (multi !== 0) begin miscompares++; $display("FAIL flag_collision: got %0d cycles required 0", multi); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
